// File: rtl/spi_pattern_sequencer.sv
// Pattern-table feeder for the 12-bit SPI master: plays table[0..length] one word per
// TX_Ready handshake, with optional idle gap between words, loop/one-shot and abort.
`timescale 1ns/1ps
module spi_pattern_sequencer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 12,
    parameter int unsigned GAP_W = 16,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             i_Clk,
    input  logic             i_Rst_L,
    input  logic             i_Wr_En,
    input  logic [IDX_W-1:0] i_Wr_Addr,
    input  logic [WIDTH-1:0] i_Wr_Data,
    input  logic [IDX_W-1:0] i_Length,
    input  logic [GAP_W-1:0] i_Gap,
    input  logic             i_Loop,
    input  logic             i_Start,
    input  logic             i_Stop,
    input  logic             i_TX_Ready,
    output logic [WIDTH-1:0] o_TX_Byte,
    output logic             o_TX_DV,
    output logic             o_Busy,
    output logic             o_Done,
    output logic [IDX_W-1:0] o_Index
);

    typedef enum logic [1:0] {StIdle, StWaitRdy, StWaitAck, StGap} state_e;

    state_e             r_state;
    logic [IDX_W-1:0]   r_index;
    logic [IDX_W-1:0]   r_len;
    logic [GAP_W-1:0]   r_gap;
    logic               r_loop;
    logic [GAP_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_tx_byte;
    logic               r_tx_dv;
    logic               r_done;
    logic [WIDTH-1:0]   r_table [DEPTH];

    state_e             w_state_nxt;
    logic [IDX_W-1:0]   w_index_nxt;
    logic [GAP_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   w_byte_nxt;
    logic               w_dv_nxt;
    logic               w_done_nxt;
    logic               w_cfg_load;
    logic               w_advance;
    logic [WIDTH-1:0]   w_rd_data;

    // Table is not reset; a same-cycle write is seen only by later issues.
    always_ff @(posedge i_Clk) begin
        if (i_Wr_En) begin
            r_table[i_Wr_Addr] <= i_Wr_Data;
        end
    end

    assign w_rd_data = r_table[r_index];

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_cnt_nxt   = r_cnt;
        w_byte_nxt  = r_tx_byte;
        w_dv_nxt    = 1'b0;
        w_done_nxt  = 1'b0;
        w_cfg_load  = 1'b0;
        w_advance   = 1'b0;

        case (r_state)
            StIdle: begin
                if (i_Start) begin
                    w_cfg_load  = 1'b1;
                    w_index_nxt = '0;
                    w_state_nxt = StWaitRdy;
                end
            end
            StWaitRdy: begin
                if (i_TX_Ready) begin
                    w_dv_nxt    = 1'b1;
                    w_byte_nxt  = w_rd_data;
                    w_state_nxt = StWaitAck;
                end
            end
            StWaitAck: begin
                if (!i_TX_Ready) begin
                    if (r_gap != '0) begin
                        w_cnt_nxt   = r_gap;
                        w_state_nxt = StGap;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            StGap: begin
                // Loaded with G on entry, so leaving on count 1 gives exactly G gap cycles.
                if (r_cnt <= 1) begin
                    w_cnt_nxt = '0;
                    w_advance = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        if (w_advance) begin
            if (r_index < r_len) begin
                w_index_nxt = r_index + 1'b1;
                w_state_nxt = StWaitRdy;
            end else if (r_loop) begin
                w_index_nxt = '0;
                w_state_nxt = StWaitRdy;
            end else begin
                w_index_nxt = '0;
                w_done_nxt  = 1'b1;
                w_state_nxt = StIdle;
            end
        end

        // Abort wins over everything, including a same-cycle start or issue.
        if (i_Stop) begin
            w_state_nxt = StIdle;
            w_index_nxt = '0;
            w_cnt_nxt   = '0;
            w_byte_nxt  = r_tx_byte;
            w_dv_nxt    = 1'b0;
            w_done_nxt  = 1'b0;
            w_cfg_load  = 1'b0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_state   <= StIdle;
            r_index   <= '0;
            r_cnt     <= '0;
            r_tx_byte <= '0;
            r_tx_dv   <= 1'b0;
            r_done    <= 1'b0;
            r_len     <= '0;
            r_gap     <= '0;
            r_loop    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_index   <= w_index_nxt;
            r_cnt     <= w_cnt_nxt;
            r_tx_byte <= w_byte_nxt;
            r_tx_dv   <= w_dv_nxt;
            r_done    <= w_done_nxt;
            if (w_cfg_load) begin
                r_len  <= i_Length;
                r_gap  <= i_Gap;
                r_loop <= i_Loop;
            end
        end
    end

    assign o_TX_Byte = r_tx_byte;
    assign o_TX_DV   = r_tx_dv;
    assign o_Busy    = (r_state != StIdle);
    assign o_Done    = r_done;
    assign o_Index   = r_index;

endmodule

// File: tb/tb_spi_pattern_sequencer.sv
// Self-checking bench for spi_pattern_sequencer: edge-timed behavioural model compared every
// cycle, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_spi_pattern_sequencer;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic [3:0]  len = '0;
    logic [15:0] gap = '0;
    logic        loop_m = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        ready;
    logic [11:0] tx_byte;
    logic        tx_dv;
    logic        busy;
    logic        done;
    logic [3:0]  idx;

    logic        auto_m = 1'b1;
    logic        auto_ready = 1'b1;
    logic        man_ready = 1'b0;
    int          low_cycles = 24;

    assign ready = auto_m ? auto_ready : man_ready;

    always #5 clk = ~clk;

    spi_pattern_sequencer #(.DEPTH(16), .WIDTH(12), .GAP_W(16)) dut (
        .i_Clk      (clk),
        .i_Rst_L    (rst_l),
        .i_Wr_En    (wr_en),
        .i_Wr_Addr  (wr_addr),
        .i_Wr_Data  (wr_data),
        .i_Length   (len),
        .i_Gap      (gap),
        .i_Loop     (loop_m),
        .i_Start    (start),
        .i_Stop     (stop),
        .i_TX_Ready (ready),
        .o_TX_Byte  (tx_byte),
        .o_TX_DV    (tx_dv),
        .o_Busy     (busy),
        .o_Done     (done),
        .o_Index    (idx)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tracks the sequence by which edge each event must happen on.
    longint      edge_n = 0;
    logic [11:0] tbl [16] = '{default: 12'h0};
    bit          m_busy = 0, m_dv = 0, m_done = 0, m_pend = 0, m_issued = 0, m_loop = 0;
    logic [11:0] m_byte = '0;
    int          m_idx = 0, m_len = 0, m_gap = 0;
    longint      m_adv_at = -1;

    task automatic m_advance();
        m_adv_at = -1;
        if (m_idx < m_len) begin
            m_idx++;
            m_pend = 1;
        end else if (m_loop) begin
            m_idx  = 0;
            m_pend = 1;
        end else begin
            m_busy = 0;
            m_done = 1;
            m_idx  = 0;
        end
    endtask

    task automatic model_step();
        m_dv   = 0;
        m_done = 0;
        if (!rst_l) begin
            m_busy = 0; m_idx = 0; m_byte = '0; m_pend = 0; m_issued = 0; m_adv_at = -1;
        end else if (stop) begin
            m_busy = 0; m_idx = 0; m_pend = 0; m_issued = 0; m_adv_at = -1;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_idx = 0; m_pend = 1; m_issued = 0; m_adv_at = -1;
                m_len = int'(len); m_gap = int'(gap); m_loop = loop_m;
            end
        end else if (m_pend) begin
            if (ready) begin
                m_dv = 1; m_byte = tbl[m_idx]; m_pend = 0; m_issued = 1;
            end
        end else if (m_issued) begin
            if (!ready) begin
                m_issued = 0;
                if (m_gap == 0) m_advance();
                else m_adv_at = edge_n + m_gap;
            end
        end else if (edge_n == m_adv_at) begin
            m_advance();
        end
        if (wr_en) tbl[wr_addr] = wr_data;
    endtask

    initial forever begin
        @(posedge clk);
        edge_n++;
        model_step();
    end

    bit cmp_en = 0;
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("model dv", tx_dv, m_dv);
            check("model byte", tx_byte, m_byte);
            check("model busy", busy, m_busy);
            check("model done", done, m_done);
            if (m_busy) check("model index", idx, m_idx);
        end
    end

    logic [11:0] dv_q [$];
    longint      dv_edge [$];
    int          done_cnt = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (tx_dv) begin
            dv_q.push_back(tx_byte);
            dv_edge.push_back(edge_n);
        end
        if (done) done_cnt++;
    end

    // Master stand-in: drops ready for low_cycles edges after each DV.
    initial forever begin
        @(posedge clk);
        #1;
        if (auto_m && tx_dv) begin
            auto_ready = 1'b0;
            repeat (low_cycles) @(posedge clk);
            #1;
            auto_ready = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wr(input logic [3:0] a, input logic [11:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run_seq(input logic [3:0] l, input logic [15:0] g, input logic lp);
        len = l; gap = g; loop_m = lp; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_dvs(input int target, input int budget, input string name);
        int k = 0;
        while (dv_q.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, " dv timeout"}, 32'(dv_q.size() >= target), 32'd1);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, " done timeout"}, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic hs(input bit do_wr);
        man_ready = 1'b1;
        if (do_wr) begin
            wr_en = 1'b1; wr_addr = 4'd2; wr_data = 12'h5A5;
        end
        @(negedge clk);
        wr_en = 1'b0;
        man_ready = 1'b0;
        @(negedge clk);
    endtask

    logic [11:0] exp_a [4] = '{12'h111, 12'h222, 12'h333, 12'hABC};
    logic [11:0] exp_r [7] = '{12'h111, 12'h222, 12'h333, 12'hABC, 12'h111, 12'h222, 12'h5A5};

    initial begin
        int d0;
        repeat (3) @(negedge clk);
        check("reset dv", tx_dv, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset index", idx, 0);
        check("reset byte", tx_byte, 0);
        cmp_en = 1;
        rst_l = 1'b1;
        @(negedge clk);

        // One-shot of four words with a slow master.
        wr(4'd0, 12'h111); wr(4'd1, 12'h222); wr(4'd2, 12'h333); wr(4'd3, 12'hABC);
        low_cycles = 24;
        run_seq(4'd3, 16'd0, 1'b0);
        check("start busy", busy, 1);
        wait_done(1, 500, "oneshot");
        repeat (3) @(negedge clk);
        check("oneshot count", dv_q.size(), 4);
        for (int i = 0; i < 4; i++) check("oneshot byte", dv_q[i], exp_a[i]);
        check("oneshot done count", done_cnt, 1);
        check("oneshot busy after", busy, 0);

        // Looping with gap 5: ready fall to next DV is 6 edges, DV to DV 7.
        dv_q.delete(); dv_edge.delete();
        low_cycles = 1;
        d0 = done_cnt;
        run_seq(4'd1, 16'd5, 1'b1);
        wait_dvs(6, 200, "loop");
        for (int i = 0; i < 6; i++) check("loop byte", dv_q[i], (i % 2 == 0) ? 12'h111 : 12'h222);
        for (int i = 0; i < 5; i++) check("loop spacing", 32'(dv_edge[i+1] - dv_edge[i]), 32'd7);
        check("loop no done", done_cnt, d0);
        pulse_stop();
        check("loop stopped", busy, 0);

        // Abort during the gap after the second word, then replay from entry 0.
        repeat (30) @(negedge clk);
        dv_q.delete(); dv_edge.delete();
        d0 = done_cnt;
        run_seq(4'd3, 16'd10, 1'b0);
        wait_dvs(2, 200, "abort");
        repeat (3) @(negedge clk);
        check("abort in gap busy", busy, 1);
        pulse_stop();
        check("abort busy", busy, 0);
        check("abort index", idx, 0);
        check("abort dv", tx_dv, 0);
        repeat (40) @(negedge clk);
        check("abort no more dv", dv_q.size(), 2);
        check("abort no done", done_cnt, d0);
        run_seq(4'd0, 16'd0, 1'b0);
        wait_done(d0 + 1, 200, "replay");
        check("replay count", dv_q.size(), 3);
        check("replay byte", dv_q[2], 12'h111);

        // Start and stop together in idle; start while busy ignored.
        repeat (30) @(negedge clk);
        dv_q.delete(); dv_edge.delete();
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        check("start+stop busy", busy, 0);
        repeat (5) @(negedge clk);
        check("start+stop no dv", dv_q.size(), 0);
        low_cycles = 3;
        d0 = done_cnt;
        run_seq(4'd3, 16'd0, 1'b0);
        repeat (8) @(negedge clk);
        run_seq(4'd0, 16'd7, 1'b1);
        wait_done(d0 + 1, 300, "restart ignored");
        repeat (3) @(negedge clk);
        check("restart count", dv_q.size(), 4);
        for (int i = 0; i < 4; i++) check("restart byte", dv_q[i], exp_a[i]);

        // Write entry 2 in the cycle it is issued: old value now, new value next lap.
        repeat (30) @(negedge clk);
        dv_q.delete(); dv_edge.delete();
        man_ready = 1'b0;
        auto_m = 1'b0;
        run_seq(4'd3, 16'd0, 1'b1);
        hs(1'b0); hs(1'b0);
        check("rbw index", idx, 2);
        hs(1'b1); hs(1'b0); hs(1'b0); hs(1'b0); hs(1'b0);
        check("rbw count", dv_q.size(), 7);
        for (int i = 0; i < 7; i++) check("rbw byte", dv_q[i], exp_r[i]);
        pulse_stop();
        auto_m = 1'b1;

        // Reset while waiting for the master to take the word.
        repeat (5) @(negedge clk);
        dv_q.delete(); dv_edge.delete();
        low_cycles = 24;
        d0 = done_cnt;
        run_seq(4'd3, 16'd0, 1'b0);
        wait_dvs(1, 50, "rst");
        @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        check("rst dv", tx_dv, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst index", idx, 0);
        check("rst byte", tx_byte, 0);
        repeat (40) @(negedge clk);
        check("rst no dv", dv_q.size(), 1);
        run_seq(4'd3, 16'd0, 1'b0);
        wait_done(d0 + 1, 500, "post rst");
        check("post rst count", dv_q.size(), 5);
        check("post rst byte0", dv_q[1], 12'h111);
        check("post rst byte1", dv_q[2], 12'h222);
        check("post rst byte2", dv_q[3], 12'h5A5);
        check("post rst byte3", dv_q[4], 12'hABC);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
